// File: rtl/bilinear_scan_ctrl.sv
// Control stage of the bilinear gray scaler: serial scale-factor division, then a destination raster scan.
// Define BILINEAR_SCALE_ROUND_EN to round the scale factors to nearest instead of truncating.
module bilinear_scan_ctrl #(
  parameter int INDEX_WIDTH = 11,
  parameter int INT_WIDTH   = 8,
  parameter int FIX_WIDTH   = 12
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [15:0]                    dest_width_i,
  input  logic [15:0]                    dest_height_i,
  input  logic [15:0]                    src_width_i,
  input  logic [15:0]                    src_height_i,
  input  logic                           ready_i,
  output logic                           busy_o,
  output logic                           cfg_err_o,
  output logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factorx_o,
  output logic [INT_WIDTH+FIX_WIDTH-1:0] scale_factory_o,
  output logic [INDEX_WIDTH-1:0]         destx_o,
  output logic [INDEX_WIDTH-1:0]         desty_o,
  output logic                           coord_valid_o,
  output logic                           line_end_o,
  output logic                           frame_end_o,
  output logic                           done_o
);

  localparam int SF_W  = INT_WIDTH + FIX_WIDTH;
  localparam int NUM_W = 29;
  localparam logic [4:0]             LAST_STEP = 5'd28;
  localparam logic [16:0]            MAX_DIM   = 17'(1) << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] ONE_IDX   = 1;

  typedef enum logic [2:0] {IDLE, DIV_X, DIV_Y, SCAN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            dest_w_q, dest_w_d;
  logic [15:0]            dest_h_q, dest_h_d;
  logic [15:0]            src_h_q, src_h_d;
  logic [15:0]            rem_q, rem_d;
  logic [NUM_W-1:0]       quo_q, quo_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [SF_W-1:0]        sfx_q, sfx_d;
  logic [SF_W-1:0]        sfy_q, sfy_d;
  logic [INDEX_WIDTH-1:0] destx_q, destx_d;
  logic [INDEX_WIDTH-1:0] desty_q, desty_d;
  logic                   busy_q, busy_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   valid_q, valid_d;
  logic                   line_end_q, line_end_d;
  logic                   frame_end_q, frame_end_d;
  logic                   done_q, done_d;

  logic [NUM_W-1:0]       num_x, num_y;
  logic                   geom_bad;
  logic [16:0]            rem_sh;
  logic [15:0]            divisor;
  logic                   div_ge;
  logic [15:0]            rem_step;
  logic [NUM_W-1:0]       quo_step;
  logic [SF_W-1:0]        quo_sat;
  logic [INDEX_WIDTH-1:0] x_next, y_next;
  logic                   next_line_end;

`ifdef BILINEAR_SCALE_ROUND_EN
  assign num_x = (NUM_W'(src_width_i) << FIX_WIDTH) + NUM_W'(dest_width_i[15:1]);
  assign num_y = (NUM_W'(src_h_q) << FIX_WIDTH) + NUM_W'(dest_h_q[15:1]);
`else
  assign num_x = NUM_W'(src_width_i) << FIX_WIDTH;
  assign num_y = NUM_W'(src_h_q) << FIX_WIDTH;
`endif

  assign geom_bad = (dest_width_i == 16'd0) || (dest_height_i == 16'd0) ||
                    (src_width_i == 16'd0) || (src_height_i == 16'd0) ||
                    ({1'b0, dest_width_i} > MAX_DIM) || ({1'b0, dest_height_i} > MAX_DIM);

  always_comb begin
    state_d     = state_q;
    dest_w_d    = dest_w_q;
    dest_h_d    = dest_h_q;
    src_h_d     = src_h_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    sfx_d       = sfx_q;
    sfy_d       = sfy_q;
    destx_d     = destx_q;
    desty_d     = desty_q;
    busy_d      = busy_q;
    cfg_err_d   = cfg_err_q;
    valid_d     = valid_q;
    line_end_d  = line_end_q;
    frame_end_d = frame_end_q;
    done_d      = done_q;

    // One restoring step: shift the next numerator bit into the remainder, subtract if it fits.
    rem_sh        = {rem_q, quo_q[NUM_W-1]};
    divisor       = (state_q == DIV_Y) ? dest_h_q : dest_w_q;
    div_ge        = rem_sh >= {1'b0, divisor};
    rem_step      = div_ge ? 16'(rem_sh - {1'b0, divisor}) : rem_sh[15:0];
    quo_step      = {quo_q[NUM_W-2:0], div_ge};
    quo_sat       = (quo_step[NUM_W-1:SF_W] != '0) ? '1 : quo_step[SF_W-1:0];
    x_next        = destx_q + ONE_IDX;
    y_next        = desty_q + ONE_IDX;
    next_line_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          dest_w_d  = dest_width_i;
          dest_h_d  = dest_height_i;
          src_h_d   = src_height_i;
          cfg_err_d = 1'b0;
          destx_d   = '0;
          desty_d   = '0;
          busy_d    = 1'b1;
          if (geom_bad) begin
            cfg_err_d = 1'b1;
            done_d    = 1'b0;
            state_d   = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = num_x;
            cnt_d   = '0;
            state_d = DIV_X;
          end
        end
      end
      DIV_X: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_STEP) begin
          sfx_d   = quo_sat;
          rem_d   = '0;
          quo_d   = num_y;
          cnt_d   = '0;
          state_d = DIV_Y;
        end
      end
      DIV_Y: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_STEP) begin
          sfy_d       = quo_sat;
          valid_d     = 1'b1;
          destx_d     = '0;
          desty_d     = '0;
          line_end_d  = (dest_w_q == 16'd1);
          frame_end_d = (dest_w_q == 16'd1) && (dest_h_q == 16'd1);
          state_d     = SCAN;
        end
      end
      SCAN: begin
        // Line/frame end flags are precomputed for the coordinate being presented next.
        if (ready_i) begin
          if (frame_end_q) begin
            valid_d     = 1'b0;
            line_end_d  = 1'b0;
            frame_end_d = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end else if (line_end_q) begin
            next_line_end = (dest_w_q == 16'd1);
            destx_d       = '0;
            desty_d       = y_next;
            line_end_d    = next_line_end;
            frame_end_d   = next_line_end && (16'(y_next) == dest_h_q - 16'd1);
          end else begin
            next_line_end = (16'(x_next) == dest_w_q - 16'd1);
            destx_d       = x_next;
            line_end_d    = next_line_end;
            frame_end_d   = next_line_end && (16'(desty_q) == dest_h_q - 16'd1);
          end
        end
      end
      DONE: begin
        // The error path enters with done low and spends one extra cycle here.
        if (done_q) begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      dest_w_q    <= '0;
      dest_h_q    <= '0;
      src_h_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      sfx_q       <= '0;
      sfy_q       <= '0;
      destx_q     <= '0;
      desty_q     <= '0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      valid_q     <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_w_q    <= dest_w_d;
      dest_h_q    <= dest_h_d;
      src_h_q     <= src_h_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      sfx_q       <= sfx_d;
      sfy_q       <= sfy_d;
      destx_q     <= destx_d;
      desty_q     <= desty_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
      valid_q     <= valid_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      done_q      <= done_d;
    end
  end

  assign busy_o          = busy_q;
  assign cfg_err_o       = cfg_err_q;
  assign scale_factorx_o = sfx_q;
  assign scale_factory_o = sfy_q;
  assign destx_o         = destx_q;
  assign desty_o         = desty_q;
  assign coord_valid_o   = valid_q;
  assign line_end_o      = line_end_q;
  assign frame_end_o     = frame_end_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_bilinear_scan_ctrl.sv
// Scoreboard bench for bilinear_scan_ctrl: stimulus queues expected factors, coordinates and completions.
module tb_bilinear_scan_ctrl;

  localparam int IW  = 11;
  localparam int SFW = 20;

  logic            clk = 1'b0;
  logic            rst_i = 1'b0;
  logic            start_i = 1'b0;
  logic            ready_i = 1'b0;
  logic [15:0]     dw = '0, dh = '0, sw = '0, sh = '0;
  logic            busy_o, cfg_err_o, coord_valid_o, line_end_o, frame_end_o, done_o;
  logic [SFW-1:0]  sfx_o, sfy_o;
  logic [IW-1:0]   destx_o, desty_o;

  bilinear_scan_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .dest_width_i    (dw),
    .dest_height_i   (dh),
    .src_width_i     (sw),
    .src_height_i    (sh),
    .ready_i         (ready_i),
    .busy_o          (busy_o),
    .cfg_err_o       (cfg_err_o),
    .scale_factorx_o (sfx_o),
    .scale_factory_o (sfy_o),
    .destx_o         (destx_o),
    .desty_o         (desty_o),
    .coord_valid_o   (coord_valid_o),
    .line_end_o      (line_end_o),
    .frame_end_o     (frame_end_o),
    .done_o          (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; bit le; bit fe;} coord_t;
  typedef struct {int sfx; int sfy;} sf_t;

  coord_t coord_q[$];
  sf_t    sf_q[$];
  bit     done_exp_q[$];
  int     compared = 0;
  int     mismatched = 0;
  logic   valid_prev = 1'b0;

`ifdef BILINEAR_SCALE_ROUND_EN
  localparam int SF_2_3 = 'hAAB;
`else
  localparam int SF_2_3 = 'hAAA;
`endif

  task automatic check_output(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_unexpected(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: DUT output with no expected entry queued", name);
  endtask

  // Monitor: compares whatever the DUT presents against the head of the matching queue.
  always @(negedge clk) begin
    if (rst_i) begin
      if (coord_valid_o && !valid_prev) begin
        if (sf_q.size() == 0) flag_unexpected("scan_entry");
        else begin
          sf_t s;
          s = sf_q.pop_front();
          check_output("scale_x", sfx_o, s.sfx);
          check_output("scale_y", sfy_o, s.sfy);
          check_output("first_x", destx_o, 0);
          check_output("first_y", desty_o, 0);
        end
      end
      if (coord_valid_o && ready_i) begin
        if (coord_q.size() == 0) flag_unexpected("coord");
        else begin
          coord_t c;
          c = coord_q.pop_front();
          check_output("coord_x", destx_o, c.x);
          check_output("coord_y", desty_o, c.y);
          check_output("line_end", line_end_o, c.le);
          check_output("frame_end", frame_end_o, c.fe);
        end
      end
      if (done_o) begin
        if (done_exp_q.size() == 0) flag_unexpected("done");
        else check_output("done_cfg_err", cfg_err_o, done_exp_q.pop_front());
      end
    end
    valid_prev = coord_valid_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int s_w, input int s_h, input int d_w, input int d_h);
    sw = 16'(s_w); sh = 16'(s_h); dw = 16'(d_w); dh = 16'(d_h);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    sw = 16'($urandom); sh = 16'($urandom); dw = 16'($urandom); dh = 16'($urandom);
  endtask

  task automatic wait_scan(output int cnt);
    cnt = 0;
    while (!coord_valid_o && cnt < 100) begin
      tick();
      cnt++;
    end
    check_output("valid_latency", cnt, 58);
  endtask

  task automatic check_reset_outputs(input string name);
    check_output({name, "_sf"}, {sfx_o, sfy_o}, 0);
    check_output({name, "_ctl"}, {busy_o, cfg_err_o, destx_o, desty_o, coord_valid_o,
                                  line_end_o, frame_end_o, done_o}, 0);
  endtask

  task automatic run_frame(input int s_w, input int s_h, input int d_w, input int d_h,
                           input int e_sfx, input int e_sfy, input bit rand_ready, input bit poke_start);
    sf_t    s;
    coord_t c;
    int     cnt;
    int     cyc;
    s.sfx = e_sfx; s.sfy = e_sfy;
    sf_q.push_back(s);
    for (int y = 0; y < d_h; y++)
      for (int x = 0; x < d_w; x++) begin
        c.x = x; c.y = y;
        c.le = (x == d_w - 1);
        c.fe = c.le && (y == d_h - 1);
        coord_q.push_back(c);
      end
    done_exp_q.push_back(1'b0);
    ready_i = 1'b0;
    apply_stimulus(s_w, s_h, d_w, d_h);
    wait_scan(cnt);
    cyc = 0;
    while (!done_o && cyc < 20000) begin
      ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start_i = poke_start && (cyc == 3);
      tick();
      cyc++;
    end
    ready_i = 1'b0;
    start_i = 1'b0;
    check_output("done_seen", done_o, 1);
    check_output("busy_in_done", busy_o, 1);
    tick();
    check_output("busy_after_done", busy_o, 0);
    check_output("done_one_cycle", done_o, 0);
    check_output("coords_left", coord_q.size(), 0);
  endtask

  task automatic run_abort(input int s_w, input int s_h, input int d_w, input int d_h,
                           input int e_sfx, input int e_sfy);
    sf_t s;
    int  cnt;
    s.sfx = e_sfx; s.sfy = e_sfy;
    sf_q.push_back(s);
    ready_i = 1'b0;
    apply_stimulus(s_w, s_h, d_w, d_h);
    wait_scan(cnt);
    tick();
    @(negedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    check_reset_outputs("reset_mid_scan");
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  task automatic run_error(input int s_w, input int s_h, input int d_w, input int d_h);
    int cnt;
    done_exp_q.push_back(1'b1);
    ready_i = 1'b1;
    apply_stimulus(s_w, s_h, d_w, d_h);
    cnt = 0;
    while (!done_o && cnt < 10) begin
      tick();
      cnt++;
    end
    check_output("err_done_latency", cnt, 1);
    check_output("err_flag", cfg_err_o, 1);
    tick();
    check_output("err_busy_after", busy_o, 0);
    tick();
    check_output("err_flag_held", cfg_err_o, 1);
    ready_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_i = 1'b1;
    tick();

    run_abort(640, 480, 1280, 960, 'h00800, 'h00800);
    run_frame(2, 2, 3, 3, SF_2_3, SF_2_3, 1'b0, 1'b0);
    run_abort(1920, 1080, 1280, 720, 'h01800, 'h01800);
    run_frame(1000, 4, 3, 4, 'hFFFFF, 'h01000, 1'b1, 1'b0);
    run_error(4, 4, 0, 5);
    run_error(4, 4, 2049, 4);
    run_error(0, 4, 4, 4);
    run_frame(8, 4, 4, 2, 'h02000, 'h02000, 1'b1, 1'b1);

    // Reset in the middle of the Y division, then a clean frame.
    ready_i = 1'b0;
    apply_stimulus(3, 3, 4, 2);
    repeat (40) tick();
    #2;
    rst_i = 1'b0;
    #1;
    check_reset_outputs("reset_mid_div");
    tick();
    rst_i = 1'b1;
    tick();
    run_frame(3, 3, 4, 2, 'h00C00, 'h01800, 1'b1, 1'b0);

    run_frame(2048, 1, 2048, 1, 'h01000, 'h01000, 1'b0, 1'b0);
    run_frame(1, 1, 1, 1, 'h01000, 'h01000, 1'b0, 1'b0);

    repeat (3) tick();
    check_output("sf_left", sf_q.size(), 0);
    check_output("done_left", done_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bilinear_scan_ctrl.md
# bilinear_scan_ctrl

Upstream control stage of the bilinear gray scaler. On a start pulse it latches the frame geometry and computes the fixed-point scale factors (src/dest) with a serial restoring divider. It then raster-scans destination coordinates with a valid/ready handshake. Its outputs drive the scaler's `destx_i`/`desty_i` and `scale_factorx_i`/`scale_factory_i`, plus the window-fetch logic that returns the 2x2 neighbourhood.

## Interface
- `INDEX_WIDTH`, 11: width of destination coordinates.
- `INT_WIDTH`, 8: integer bits of the scale factor.
- `FIX_WIDTH`, 12: fraction bits of the scale factor.

- `clk_i`  in  1  single clock.
- `rst_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  frame start; sampled only in IDLE.
- `dest_width_i`, `dest_height_i`, `src_width_i`, `src_height_i`  in  16 each  frame geometry; sampled on the accepted start.
- `ready_i`  in  1  downstream accepts the current coordinate.
- `busy_o`  out  1  high in any state other than IDLE.
- `cfg_err_o`  out  1  illegal geometry on the last start; held until the next accepted start.
- `scale_factorx_o`, `scale_factory_o`  out  INT_WIDTH+FIX_WIDTH each  registered quotients; stable from SCAN entry until the next start.
- `destx_o`, `desty_o`  out  INDEX_WIDTH each  current destination coordinate.
- `coord_valid_o`  out  1  coordinate valid.
- `line_end_o`  out  1  `coord_valid_o` and `destx_o == dest_width-1`.
- `frame_end_o`  out  1  `line_end_o` and `desty_o == dest_height-1`.
- `done_o`  out  1  one-cycle pulse at frame completion.

## Operation
- States are IDLE, DIV_X, DIV_Y, SCAN and DONE.
- **IDLE**
  - If `start_i` is high, latch the four dimensions, clear `cfg_err_o` and zero the coordinate counters.
  - If any dimension is 0, or a dest dimension exceeds 2^INDEX_WIDTH: set `cfg_err_o` and go to DONE. No coordinates are issued.
  - Otherwise go to DIV_X.
- **DIV_X / DIV_Y**
  - Numerator N = src<<FIX_WIDTH, extended to 29 bits. Divisor is the dest dimension (16 bits).
  - Restoring division at one quotient bit per cycle, MSB first, for exactly 29 cycles per axis.
  - The quotient Q is 29 bits. If Q ≥ 2^(INT_WIDTH+FIX_WIDTH), the output saturates to all ones; otherwise it is Q truncated to INT_WIDTH+FIX_WIDTH bits. Saturation is not an error.
  - The X result is written at the DIV_X→DIV_Y transition; the Y result at the DIV_Y→SCAN transition.
- **SCAN**
  - `coord_valid_o` is high for the whole state.
  - A handshake (`coord_valid_o && ready_i`) advances `destx_o`. At `dest_width-1`, `destx_o` wraps to 0 and `desty_o` increments.
  - Coordinates hold stable while `ready_i` is low.
  - A handshake on `frame_end_o` goes to DONE.
- **DONE**
  - `done_o` is high for one cycle, then the block returns to IDLE.
- **Rules**
  - `start_i` outside IDLE is ignored, including in the DONE cycle.
  - Geometry inputs may change freely after the start is accepted.
  - Asserting `rst_i` low at any point, including mid-division or mid-scan, returns the block to IDLE immediately. The partial frame is discarded.

## Timing
- **Reset values**: all outputs 0; state IDLE.
- **Division latency**: start is sampled at edge E. DIV_X covers edges E+1..E+29 and DIV_Y covers E+30..E+58.
  - The scale factors are valid after edge E+58.
  - `coord_valid_o` first rises after edge E+58, with `destx_o` = `desty_o` = 0.
- **Scan throughput**: one coordinate per cycle while `ready_i` is held high. A W×H frame takes W·H SCAN cycles when the consumer never stalls.
- **Completion**: `done_o` is high in the cycle after the final handshake; `busy_o` falls one cycle later.
- **Error path**: start at E → DONE after E+1 → `done_o` high in that cycle → IDLE after E+2.
- **Registered outputs**: all outputs are registered. `line_end_o` and `frame_end_o` are registered alongside the coordinates, not decoded combinationally from `ready_i`.

## Configuration
- `BILINEAR_SCALE_ROUND_EN`
  - Defined: N = (src<<FIX_WIDTH) + (dest>>1), giving round-to-nearest quotients.
  - Undefined: N = src<<FIX_WIDTH, giving truncated quotients.
  - Cycle counts, widths and saturation rules are identical in both builds.

## Test plan
- src 640x480, dest 1280x960, `ready_i`=1 → `scale_factorx_o` = `scale_factory_o` = 0x00800. `coord_valid_o` rises after E+58. 1,228,800 handshakes; `frame_end_o` at (1279,959); `done_o` follows one cycle later.
- src 1920x1080, dest 1280x720 → both factors 0x01800. src 1000x4, dest 3x4 → x saturates to 0xFFFFF, y = 0x01000.
- src 2x2, dest 3x3 → factor 0x00AAA with the macro undefined; 0x00AAB with `BILINEAR_SCALE_ROUND_EN` defined.
- dest width 0, or dest width 2049 with INDEX_WIDTH=11 → `cfg_err_o`=1. `done_o` pulses after E+1. `coord_valid_o` never rises.
- dest 4x2 with `ready_i` toggled randomly → coordinates hold while stalled. Order is (0,0)…(3,0),(0,1)…(3,1). `line_end_o` at x=3, `frame_end_o` only at (3,1). `start_i` pulsed mid-scan is ignored.
- `rst_i` pulled low during DIV_Y and again mid-SCAN → all outputs 0 immediately. A fresh start then produces a correct full frame.
